spram_ctrl: RTL and testbench

//  Sequencer between a 32-bit single-requester memory port and one 16-bit SB_SPRAM256KA.

---
 rtl/spram_ctrl_pkg.sv | 26 ++
 rtl/spram_pwr_timer.sv | 82 ++++++++
 rtl/spram_ctrl.sv | 144 ++++++++++++++
 tb/tb_spram_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the SPRAM sequencer and its power timer.
package spram_ctrl_pkg;

   // Width of the SPRAM word address before the half-select bit is appended.
   localparam int SPRAM_WORD_W = 13;

   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_LO   = 2'd1,
      ACC_HI   = 2'd2,
      ACC_TAIL = 2'd3
   } acc_state_t;

   typedef enum logic [1:0] {
      PWR_RUN   = 2'd0,
      PWR_STBY  = 2'd1,
      PWR_SLEEP = 2'd2,
      PWR_WAKE  = 2'd3
   } pwr_state_t;

   // Two byte enables become a four-bit nibble write mask.
   function automatic logic [3:0] mask_expand(input logic [1:0] be);
      return {be[1], be[1], be[0], be[0]};
   endfunction

endpackage

// File: rtl/spram_pwr_timer.sv
// Idle/wake timing and power-state FSM for one SPRAM macro.
//
// state     | meaning
// ----------+---------------------------------------------------------
// PWR_RUN   | RAM fully powered; idle_cnt counts idle cycles
// PWR_STBY  | STANDBY asserted; idle_cnt keeps counting towards sleep
// PWR_SLEEP | SLEEP and STANDBY asserted; waits for a request or !pwr_en
// PWR_WAKE  | SLEEP released; wake_cnt down-counts the settle time
module spram_pwr_timer
   import spram_ctrl_pkg::*;
#(
   parameter int STBY_IDLE  = 16,
   parameter int SLEEP_IDLE = 1024,
   parameter int WAKE_CYC   = 3,
   parameter int CNT_W      = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       busy,
   input  logic       req_valid,
   input  logic       pwr_en,
   output logic       awake,
   output logic       standby,
   output logic       sleep,
   output pwr_state_t state
);

   localparam logic [CNT_W-1:0] STBY_TC  = CNT_W'(STBY_IDLE - 1);
   localparam logic [CNT_W-1:0] SLEEP_TC = CNT_W'(SLEEP_IDLE - 1);
   localparam logic [CNT_W-1:0] WAKE_TC  = CNT_W'(WAKE_CYC - 1);

   pwr_state_t       state_nxt;
   logic [CNT_W-1:0] idle_cnt;
   logic [CNT_W-1:0] wake_cnt;
   logic             idle_tick;

   // A request on the threshold cycle suppresses the tick, so the request wins.
   assign idle_tick = !busy && !req_valid && pwr_en;

   // Power state register.
   always_ff @(posedge clk) begin
      if (reset) state <= PWR_RUN;
      else       state <= state_nxt;
   end

   // Power state transitions.
   always_comb begin
      state_nxt = state;
      unique case (state)
         PWR_RUN:   if (idle_tick && idle_cnt == STBY_TC) state_nxt = PWR_STBY;
         PWR_STBY:  if (req_valid || !pwr_en) state_nxt = PWR_RUN;
                    else if (idle_tick && idle_cnt == SLEEP_TC) state_nxt = PWR_SLEEP;
         PWR_SLEEP: if (req_valid || !pwr_en) state_nxt = PWR_WAKE;
         PWR_WAKE:  if (wake_cnt == '0) state_nxt = PWR_RUN;
         default:   state_nxt = PWR_RUN;
      endcase
   end

   // Idle up-counter (shared by both thresholds) and wake settle down-counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt <= '0;
         wake_cnt <= '0;
      end else begin
         case (state)
            PWR_RUN, PWR_STBY: idle_cnt <= idle_tick ? idle_cnt + CNT_W'(1) : '0;
            PWR_SLEEP:         if (state_nxt == PWR_WAKE) idle_cnt <= '0;
            default:           idle_cnt <= '0;
         endcase
         if (state == PWR_SLEEP && state_nxt == PWR_WAKE) wake_cnt <= WAKE_TC;
         else if (state == PWR_WAKE && wake_cnt != '0)    wake_cnt <= wake_cnt - CNT_W'(1);
      end
   end

   // Macro power pins decoded from the state.
   always_comb begin
      awake   = (state == PWR_RUN);
      standby = (state == PWR_STBY) || (state == PWR_SLEEP);
      sleep   = (state == PWR_SLEEP);
   end

endmodule

// File: rtl/spram_ctrl.sv
// 32-bit request port to 16-bit SPRAM sequencer: two halfword beats per word.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ACC_IDLE | no access; ready when the RAM is awake
// ACC_LO   | low halfword beat, address {word,0}
// ACC_HI   | high halfword beat, address {word,1}; low read half arrives
// ACC_TAIL | reads only: high read half arrives, RAM deselected
module spram_ctrl
   import spram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int STBY_IDLE  = 16,
   parameter int SLEEP_IDLE = 1024,
   parameter int WAKE_CYC   = 3,
   parameter int CNT_W      = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pwr_en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [3:0]        req_be,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [13:0]       ram_addr,
   output logic [3:0]        ram_mask,
   output logic [15:0]       ram_din,
   input  logic [15:0]       ram_dout,
   output logic              ram_standby,
   output logic              ram_sleep,
   output logic [1:0]        pwr_state
);

   acc_state_t              state;
   acc_state_t              state_nxt;
   logic [ADDR_W-1:0]       addr_q;
   logic                    we_q;
   logic [3:0]              be_q;
   logic [31:0]             wdata_q;
   logic [31:0]             rdata_q;
   logic                    resp_q;
   logic [SPRAM_WORD_W-1:0] addr_ext;
   logic                    awake;
   logic                    accept;
   pwr_state_t              pwr_st;

   spram_pwr_timer #(
      .STBY_IDLE  (STBY_IDLE),
      .SLEEP_IDLE (SLEEP_IDLE),
      .WAKE_CYC   (WAKE_CYC),
      .CNT_W      (CNT_W)
   ) u_pwr_timer (
      .clk       (clk),
      .reset     (reset),
      .busy      (state != ACC_IDLE),
      .req_valid (req_valid),
      .pwr_en    (pwr_en),
      .awake     (awake),
      .standby   (ram_standby),
      .sleep     (ram_sleep),
      .state     (pwr_st)
   );

   // Ready is masked during reset so every output reads 0 while it is held.
   assign req_ready  = (state == ACC_IDLE) && awake && !reset;
   assign accept     = req_valid && req_ready;
   assign addr_ext   = SPRAM_WORD_W'(addr_q);
   assign resp_valid = resp_q;
   assign resp_rdata = rdata_q;
   assign pwr_state  = pwr_st;

   // Access state register.
   always_ff @(posedge clk) begin
      if (reset) state <= ACC_IDLE;
      else       state <= state_nxt;
   end

   // Access sequencing: writes skip TAIL since no read data is outstanding.
   always_comb begin
      state_nxt = state;
      case (state)
         ACC_IDLE: if (accept) state_nxt = ACC_LO;
         ACC_LO:   state_nxt = ACC_HI;
         ACC_HI:   state_nxt = we_q ? ACC_IDLE : ACC_TAIL;
         ACC_TAIL: state_nxt = ACC_IDLE;
         default:  state_nxt = ACC_IDLE;
      endcase
   end

   // Request capture, read-data merge and the one-cycle response pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            be_q    <= req_be;
            wdata_q <= req_wdata;
         end
         if (state == ACC_HI && !we_q) rdata_q[15:0]  <= ram_dout;
         if (state == ACC_TAIL)        rdata_q[31:16] <= ram_dout;
         resp_q <= (state == ACC_HI && we_q) || (state == ACC_TAIL);
      end
   end

   // SPRAM pin drive; everything idles at 0 outside the two beats.
   always_comb begin
      ram_cs   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_mask = '0;
      ram_din  = '0;
      case (state)
         ACC_LO: begin
            ram_cs   = 1'b1;
            ram_we   = we_q;
            ram_addr = {addr_ext, 1'b0};
            ram_din  = wdata_q[15:0];
            ram_mask = we_q ? mask_expand(be_q[1:0]) : 4'b0000;
         end
         ACC_HI: begin
            ram_cs   = 1'b1;
            ram_we   = we_q;
            ram_addr = {addr_ext, 1'b1};
            ram_din  = wdata_q[31:16];
            ram_mask = we_q ? mask_expand(be_q[3:2]) : 4'b0000;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl with a behavioural SPRAM (1-cycle read, nibble mask).
module tb_spram_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        pwr_en;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_be;
   logic [12:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        ram_cs;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [3:0]  ram_mask;
   logic [15:0] ram_din;
   logic [15:0] ram_dout;
   logic        ram_standby;
   logic        ram_sleep;
   logic [1:0]  pwr_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [18:0] beat_q[$];
   int          cs_in_sleep = 0;
   int          stby_seen   = 0;
   logic [15:0] mem [0:16383];

   always #5 clk = ~clk;

   spram_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .pwr_en      (pwr_en),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_be      (req_be),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_mask    (ram_mask),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .ram_standby (ram_standby),
      .ram_sleep   (ram_sleep),
      .pwr_state   (pwr_state)
   );

   // SPRAM model: mask bit set = nibble written; read data one cycle later.
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            for (int i = 0; i < 4; i++)
               if (ram_mask[i]) mem[ram_addr][i*4 +: 4] <= ram_din[i*4 +: 4];
         end else begin
            ram_dout <= mem[ram_addr];
         end
      end
   end

   // Beat log and power-pin observation.
   always @(negedge clk) begin
      if (ram_cs) begin
         beat_q.push_back({ram_we, ram_mask, ram_addr});
         if (ram_sleep) cs_in_sleep++;
      end
      if (ram_standby) stby_seen++;
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one access (call at a negedge); returns read data and cycles from accept to resp.
   task automatic access(input logic we, input logic [3:0] be, input logic [12:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
      int waitc;
      req_we = we; req_be = be; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      #1;
      waitc = 0;
      while (!req_ready && waitc < 2000) begin
         @(negedge clk); #1;
         waitc++;
      end
      if (!req_ready) chk_val("ready_wait", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 10);
      rd = resp_rdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int          lat;
      int          resp_cnt;

      reset = 1'b1; pwr_en = 1'b0; req_valid = 1'b0;
      req_we = 1'b0; req_be = 4'h0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_val("rst_rdata", resp_rdata, 32'h0);
      chk_val("rst_ctl", {22'd0, resp_valid, req_ready, ram_cs, ram_we, ram_standby,
                          ram_sleep, pwr_state, ram_mask}, 32'h0);
      chk_val("rst_bus", {2'd0, ram_addr, ram_din}, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk_val("rst_rel_ready", {31'd0, req_ready}, 32'd1);

      // 1: full-word write then read back, beat addresses and latencies
      beat_q.delete();
      access(1'b1, 4'hF, 13'h005, 32'hDEADBEEF, rd, lat);
      chk_val("t1_wr_lat", lat, 32'd3);
      chk_val("t1_wr_nbeats", beat_q.size(), 32'd2);
      if (beat_q.size() >= 2) begin
         chk_val("t1_wr_beat_lo", {13'd0, beat_q[0]}, {13'd0, 1'b1, 4'hF, 14'h00A});
         chk_val("t1_wr_beat_hi", {13'd0, beat_q[1]}, {13'd0, 1'b1, 4'hF, 14'h00B});
      end
      beat_q.delete();
      access(1'b0, 4'h0, 13'h005, 32'h0, rd, lat);
      chk_val("t1_rd_data", rd, 32'hDEADBEEF);
      chk_val("t1_rd_lat", lat, 32'd4);
      if (beat_q.size() >= 2) begin
         chk_val("t1_rd_beat_lo", {13'd0, beat_q[0]}, {13'd0, 1'b0, 4'h0, 14'h00A});
         chk_val("t1_rd_beat_hi", {13'd0, beat_q[1]}, {13'd0, 1'b0, 4'h0, 14'h00B});
      end

      // 2: partial write of byte 2 only
      beat_q.delete();
      access(1'b1, 4'b0100, 13'h005, 32'h00550000, rd, lat);
      if (beat_q.size() >= 2) begin
         chk_val("t2_mask_lo", {28'd0, beat_q[0][17:14]}, 32'h0);
         chk_val("t2_mask_hi", {28'd0, beat_q[1][17:14]}, 32'h3);
      end
      access(1'b0, 4'h0, 13'h005, 32'h0, rd, lat);
      chk_val("t2_rd_data", rd, 32'hDE55BEEF);

      // 3: standby after 16 idle cycles, then wake by request
      pwr_en = 1'b1;
      repeat (15) @(negedge clk);
      chk_val("t3_stby_early", {31'd0, ram_standby}, 32'd0);
      @(negedge clk);
      chk_val("t3_stby", {29'd0, ram_standby, pwr_state}, {29'd0, 1'b1, 2'd1});
      req_we = 1'b0; req_be = 4'h0; req_addr = 13'h005; req_valid = 1'b1;
      #1;
      chk_val("t3_ready_in_stby", {31'd0, req_ready}, 32'd0);
      @(negedge clk); #1;
      chk_val("t3_run_ready", {28'd0, req_ready, ram_standby, pwr_state}, {28'd0, 1'b1, 1'b0, 2'd0});
      access(1'b0, 4'h0, 13'h005, 32'h0, rd, lat);
      chk_val("t3_rd_data", rd, 32'hDE55BEEF);
      chk_val("t3_rd_lat", lat, 32'd4);

      // 4: sleep after 1024 idle cycles, wake sequence
      repeat (1023) @(negedge clk);
      chk_val("t4_pre_sleep", {29'd0, ram_sleep, ram_standby, 1'b0}, {29'd0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      chk_val("t4_sleep", {28'd0, ram_sleep, ram_standby, pwr_state}, {28'd0, 1'b1, 1'b1, 2'd2});
      repeat (20) @(negedge clk);
      req_we = 1'b0; req_be = 4'h0; req_addr = 13'h005; req_valid = 1'b1;
      #1;
      chk_val("t4_ready_sleep", {29'd0, req_ready, pwr_state}, {29'd0, 1'b0, 2'd2});
      @(negedge clk);
      chk_val("t4_wake1", {28'd0, req_ready, ram_sleep, pwr_state}, {28'd0, 1'b0, 1'b0, 2'd3});
      chk_val("t4_wake1_stby", {31'd0, ram_standby}, 32'd0);
      repeat (2) @(negedge clk);
      chk_val("t4_wake3", {29'd0, req_ready, pwr_state}, {29'd0, 1'b0, 2'd3});
      @(negedge clk);
      chk_val("t4_run", {29'd0, req_ready, pwr_state}, {29'd0, 1'b1, 2'd0});
      access(1'b0, 4'h0, 13'h005, 32'h0, rd, lat);
      chk_val("t4_rd_data", rd, 32'hDE55BEEF);
      chk_val("t4_cs_in_sleep", cs_in_sleep, 32'd0);

      // 6: request on the last idle cycle before standby wins
      repeat (15) @(negedge clk);
      stby_seen = 0;
      req_we = 1'b1; req_be = 4'hF; req_addr = 13'h007; req_wdata = 32'h12345678; req_valid = 1'b1;
      #1;
      chk_val("t6_ready", {31'd0, req_ready}, 32'd1);
      access(1'b1, 4'hF, 13'h007, 32'h12345678, rd, lat);
      chk_val("t6_wr_lat", lat, 32'd3);
      chk_val("t6_no_stby", stby_seen, 32'd0);
      chk_val("t6_pwr_run", {30'd0, pwr_state}, 32'd0);
      access(1'b0, 4'h0, 13'h007, 32'h0, rd, lat);
      chk_val("t6_rd_data", rd, 32'h12345678);

      // 5: reset during the HI beat of a read aborts it
      pwr_en = 1'b0;
      req_we = 1'b0; req_be = 4'h0; req_addr = 13'h005; req_valid = 1'b1;
      #1;
      chk_val("t5_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk_val("t5_lo_addr", {17'd0, ram_cs, ram_addr}, {17'd0, 1'b1, 14'h00A});
      @(negedge clk);
      chk_val("t5_hi_addr", {17'd0, ram_cs, ram_addr}, {17'd0, 1'b1, 14'h00B});
      reset = 1'b1;
      @(negedge clk);
      chk_val("t5_rst_rdata", resp_rdata, 32'h0);
      chk_val("t5_rst_ctl", {22'd0, resp_valid, req_ready, ram_cs, ram_we, ram_standby,
                             ram_sleep, pwr_state, ram_mask}, 32'h0);
      chk_val("t5_rst_bus", {2'd0, ram_addr, ram_din}, 32'h0);
      reset = 1'b0;
      resp_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) resp_cnt++;
      end
      chk_val("t5_no_resp", resp_cnt, 32'd0);
      access(1'b0, 4'h0, 13'h005, 32'h0, rd, lat);
      chk_val("t5_rd_after", rd, 32'hDE55BEEF);
      chk_val("t5_rd_lat", lat, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
